// File: rtl/mlp_sched_pkg.sv
// Shared types and sizing helpers for the MLP inference frame scheduler.
package mlp_sched_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ARGMAX, HOLD} sched_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_OUTPUT_SIZE    = 5;

  function automatic int cls_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CLS_W = cls_w(DEF_OUTPUT_SIZE);

endpackage

// File: rtl/seq_argmax.sv
// Sequential argmax over a captured score vector: one signed compare per cycle,
// ties keep the lowest index. done_o pulses on the final compare with index_o valid.
module seq_argmax
  import mlp_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [N-1:0][WIDTH-1:0]   vec_i,
  output logic                      done_o,
  output logic [cls_w(N)-1:0]       index_o
);

  localparam int IW = cls_w(N);

  logic                    active_q;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           best_q;
  logic signed [WIDTH-1:0] cand;
  logic signed [WIDTH-1:0] lead;

  assign cand    = vec_i[idx_q];
  assign lead    = vec_i[best_q];
  // index_o already folds in this cycle's compare so the last step needs no extra cycle
  assign index_o = (cand > lead) ? idx_q : best_q;
  assign done_o  = active_q && (idx_q == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      best_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      idx_q    <= IW'(1);
      best_q   <= '0;
    end else if (active_q) begin
      best_q <= index_o;
      if (done_o) active_q <= 1'b0;
      else        idx_q    <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/mlp_inference_scheduler.sv
// Frame-level controller for the jet-tagging MLP: buffers one frame, launches the network,
// waits with a timeout, runs a sequential argmax and hands the result downstream.
module mlp_inference_scheduler
  import mlp_sched_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NFRAC          = 10,
  parameter int INPUT_SIZE     = 16,
  parameter int OUTPUT_SIZE    = 5,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [INPUT_SIZE-1:0][WIDTH-1:0]    s_data,
  output logic                                net_start,
  output logic [INPUT_SIZE-1:0][WIDTH-1:0]    net_data,
  input  logic                                net_done,
  input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   net_result,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   m_data,
  output logic [cls_w(OUTPUT_SIZE)-1:0]       m_class,
  output logic                                m_timeout,
  output logic                                busy,
  output logic [15:0]                         frame_cnt,
  output logic [15:0]                         timeout_cnt,
  output sched_state_t                        dbg_state
);

  localparam int CW     = cls_w(OUTPUT_SIZE);
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  if (NFRAC >= WIDTH || OUTPUT_SIZE < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mlp_inference_scheduler: invalid parameter set");
  end

  sched_state_t                        state_q, state_d;
  logic                                pend_v_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]    pend_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]    net_data_q;
  logic [WCNT_W-1:0]                   wcnt_q;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   m_data_q;
  logic [CW-1:0]                       m_class_q;
  logic                                m_timeout_q;
  logic [15:0]                         frame_cnt_q;
  logic [15:0]                         timeout_cnt_q;

  logic          accept, capture, expire, handoff;
  logic          am_done;
  logic [CW-1:0] am_index;

  // Both ports transfer on the rising edge where valid && ready; a source never
  // drops valid or changes data while waiting, and ready here never depends on valid.
  assign accept = s_valid && !pend_v_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    expire  = 1'b0;
    handoff = 1'b0;
    case (state_q)
      IDLE:   if (pend_v_q) state_d = LAUNCH;
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (net_done) begin
          capture = 1'b1;
          state_d = ARGMAX;
        end else if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          state_d = HOLD;
        end
      end
      ARGMAX: if (am_done) state_d = HOLD;
      HOLD: begin
        if (m_ready) begin
          handoff = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      pend_v_q      <= 1'b0;
      pend_q        <= '0;
      net_data_q    <= '0;
      wcnt_q        <= '0;
      m_data_q      <= '0;
      m_class_q     <= '0;
      m_timeout_q   <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_q   <= s_data;
        pend_v_q <= 1'b1;
      end
      if (state_q == LAUNCH) begin
        net_data_q <= pend_q;
        pend_v_q   <= 1'b0;
        wcnt_q     <= '0;
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (capture) begin
        m_data_q    <= net_result;
        m_timeout_q <= 1'b0;
      end
      if (expire) begin
        m_data_q    <= '0;
        m_class_q   <= '0;
        m_timeout_q <= 1'b1;
        if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
      if (state_q == ARGMAX && am_done) m_class_q <= am_index;
      if (handoff) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  seq_argmax #(
    .WIDTH (WIDTH),
    .N     (OUTPUT_SIZE)
  ) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .start_i (capture),
    .vec_i   (m_data_q),
    .done_o  (am_done),
    .index_o (am_index)
  );

  assign s_ready     = !pend_v_q;
  assign net_start   = (state_q == LAUNCH);
  assign net_data    = net_data_q;
  assign m_valid     = (state_q == HOLD);
  assign m_data      = m_data_q;
  assign m_class     = m_class_q;
  assign m_timeout   = m_timeout_q;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mlp_inference_scheduler.sv
// Directed and random checks of the MLP frame scheduler against a network model and scoreboard.
module tb_mlp_inference_scheduler;
  import mlp_sched_pkg::*;

  localparam int WIDTH       = 16;
  localparam int INPUT_SIZE  = 16;
  localparam int OUTPUT_SIZE = 5;
  localparam int TMO         = 8;
  localparam int EW          = 1 + CLS_W + OUTPUT_SIZE * WIDTH;

  typedef logic [INPUT_SIZE-1:0][WIDTH-1:0]  frame_t;
  typedef logic [OUTPUT_SIZE-1:0][WIDTH-1:0] res_t;

  // clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid, s_ready, net_start, net_done, m_valid, m_ready, m_timeout, busy;
  frame_t       s_data, net_data;
  res_t         net_result, m_data;
  logic [CLS_W-1:0] m_class;
  logic [15:0]  frame_cnt, timeout_cnt;
  sched_state_t dbg_state;

  always #5 clk = ~clk;

  // network model and forced-done controls
  logic  model_done, force_done, net_auto, from_data;
  res_t  model_res, model_vec, force_res;
  int    net_lat, cnt;
  int    lat_q[$];

  assign net_done   = model_done | force_done;
  assign net_result = force_done ? force_res : model_res;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  mlp_inference_scheduler #(
    .WIDTH(WIDTH), .NFRAC(10), .INPUT_SIZE(INPUT_SIZE),
    .OUTPUT_SIZE(OUTPUT_SIZE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .net_start(net_start), .net_data(net_data),
    .net_done(net_done), .net_result(net_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_class(m_class), .m_timeout(m_timeout), .busy(busy),
    .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_class(input res_t v);
    int best = 0;
    for (int i = 1; i < OUTPUT_SIZE; i++)
      if ($signed(v[i]) > $signed(v[best])) best = i;
    return best;
  endfunction

  function automatic logic [EW-1:0] exp_ok(input res_t v);
    return {1'b0, CLS_W'(ref_class(v)), v};
  endfunction

  function automatic logic [EW-1:0] exp_tmo();
    logic [EW-1:0] e = '0;
    e[EW-1] = 1'b1;
    return e;
  endfunction

  function automatic res_t mk_res(input int a, input int b, input int c, input int d, input int e);
    res_t r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d); r[4] = 16'(e);
    return r;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < INPUT_SIZE; k++)
      f[k] = (k < OUTPUT_SIZE) ? 16'($urandom_range(0, 15)) - 16'd8 : 16'($urandom);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t d);
    bit ok = 0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) begin
        ok = 1;
        step();
        break;
      end
      step();
    end
    s_valid = 1'b0;
    check("accept", ok, 1'b1);
  endtask

  // From the cycle after an accept: find net_start, then count cycles until m_valid.
  task automatic launch_and_measure(output int n);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (net_start) begin
        ok = 1;
        break;
      end
      step();
    end
    check("launch_seen", ok, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (m_valid) break;
    end
  endtask

  task automatic wait_frames(input int target);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (frame_cnt == 16'(target)) begin
        ok = 1;
        break;
      end
      step();
    end
    check("frame_wait", ok, 1'b1);
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    check("valid_wait", ok, 1'b1);
  endtask

  // network model: done net_lat cycles after net_start (0 = never)
  initial begin
    model_done = 1'b0;
    model_res  = '0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          model_res  = from_data ? res_t'(net_data[OUTPUT_SIZE-1:0]) : model_vec;
        end
      end
      if (net_start && net_auto) cnt = (lat_q.size() > 0) ? lat_q.pop_front() : net_lat;
    end
  end

  // result monitor: compare each handshake against the expected queue
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("result", {m_timeout, m_class, m_data}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, starts, acc_c, fc0, sent, lat;
    bit acc;
    frame_t f;
    res_t v1, v2, v3, v4, ones;
    v1   = mk_res(-3072, 512, 2304, 2304, 1024);
    v2   = mk_res(100, -5, 300, 299, 300);
    v3   = mk_res(0, -1, -2, -3, 5);
    v4   = mk_res(0, 0, 0, 7, 0);
    ones = mk_res(1024, 1024, 1024, 1024, 1024);

    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    force_done = 1'b0; force_res = '0; net_auto = 1'b1; from_data = 1'b0;
    net_lat = 7; model_vec = v1;

    // reset state
    step(); step(); step();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_outputs", {net_start, m_timeout, m_class, m_data, net_data}, '0);
    check("rst_counters", {frame_cnt, timeout_cnt}, 32'd0);
    reset = 1'b1;
    step();

    // 1: basic frame, latency and argmax with tie
    m_ready = 1'b1;
    exp_q.push_back(exp_ok(v1));
    send_frame(rand_frame());
    step();
    check("t1_launch_latency", net_start, 1'b1);
    check("t1_busy", busy, 1'b1);
    launch_and_measure(n);
    check("t1_valid_latency", n, 12);
    check("t1_class", m_class, CLS_W'(2));
    step();
    check("t1_frame_cnt", frame_cnt, 16'd1);
    check("t1_valid_drop", m_valid, 1'b0);

    // 2: backpressure with a second frame buffered
    m_ready = 1'b0; model_vec = v2;
    exp_q.push_back(exp_ok(v2));
    send_frame(rand_frame());
    step();
    check("t2_launch", net_start, 1'b1);
    check("t2_ready_in_launch", s_ready, 1'b0);
    step();
    check("t2_ready_after_launch", s_ready, 1'b1);
    exp_q.push_back(exp_ok(v2));
    send_frame(rand_frame());
    check("t2_pending_full", s_ready, 1'b0);
    s_data = rand_frame(); s_valid = 1'b1;
    starts = 0; acc_c = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) acc_c++;
      step();
      if (net_start) starts++;
    end
    s_valid = 1'b0;
    check("t2_third_rejected", acc_c, 0);
    check("t2_single_launch", starts, 0);
    check("t2_holding", m_valid, 1'b1);
    m_ready = 1'b1;
    wait_frames(3);
    check("t2_drained", exp_q.size(), 0);

    // 3: timeout, done on last WAIT cycle, done one cycle too late
    net_lat = 0;
    exp_q.push_back(exp_tmo());
    send_frame(rand_frame());
    launch_and_measure(n);
    check("t3_tmo_latency", n, 9);
    check("t3_tmo_flag", m_timeout, 1'b1);
    step();
    check("t3_tmo_cnt", timeout_cnt, 16'd1);
    net_lat = 8; model_vec = v3;
    exp_q.push_back(exp_ok(v3));
    send_frame(rand_frame());
    launch_and_measure(n);
    check("t3_edge_latency", n, 13);
    step();
    check("t3_edge_tmo_cnt", timeout_cnt, 16'd1);
    net_lat = 9;
    exp_q.push_back(exp_tmo());
    send_frame(rand_frame());
    launch_and_measure(n);
    check("t3_late_latency", n, 9);
    step();
    check("t3_late_tmo_cnt", timeout_cnt, 16'd2);
    check("t3_frame_cnt", frame_cnt, 16'd6);

    // 4: reset during WAIT, then during HOLD
    net_lat = 7;
    send_frame(rand_frame());
    step(); step(); step(); step();
    check("t4_in_wait", dbg_state, WAIT);
    reset = 1'b0; step(); reset = 1'b1;
    check("t4w_ready", s_ready, 1'b1);
    check("t4w_idle", {busy, m_valid, net_start}, 3'b000);
    check("t4w_counters", {frame_cnt, timeout_cnt}, 32'd0);
    check("t4w_net_data", net_data, '0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (m_valid || busy) n++;
    end
    check("t4w_late_done_ignored", n, 0);
    m_ready = 1'b0; net_lat = 3; model_vec = v4;
    send_frame(rand_frame());
    launch_and_measure(n);
    check("t4h_latency", n, 8);
    check("t4h_class", m_class, CLS_W'(3));
    reset = 1'b0; step(); reset = 1'b1;
    check("t4h_outputs", {m_valid, m_timeout, m_class, m_data}, '0);
    check("t4h_ready", s_ready, 1'b1);
    check("t4h_frame_cnt", frame_cnt, 16'd0);
    m_ready = 1'b1;

    // 5: spurious done in IDLE and LAUNCH; all-equal scores
    net_auto = 1'b0;
    force_res = mk_res(9, 9, 9, 9, 9);
    force_done = 1'b1; step(); force_done = 1'b0;
    check("t5_idle_ignored", dbg_state, IDLE);
    check("t5_idle_no_capture", m_data, '0);
    send_frame(rand_frame());
    step();
    check("t5_launch", net_start, 1'b1);
    force_res = mk_res(5, 4, 3, 2, 1);
    force_done = 1'b1; step(); force_done = 1'b0;
    check("t5_launch_ignored", dbg_state, WAIT);
    step(); step();
    exp_q.push_back(exp_ok(ones));
    force_res = ones;
    force_done = 1'b1; step(); force_done = 1'b0;
    check("t5_argmax", dbg_state, ARGMAX);
    wait_valid();
    step();
    check("t5_frame_cnt", frame_cnt, 16'd1);

    // 6: random frames, latencies and backpressure
    net_auto = 1'b1; from_data = 1'b1;
    fc0 = int'(frame_cnt); sent = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (sent == 30 && exp_q.size() == 0) break;
      m_ready = 1'($urandom_range(0, 1));
      if (!s_valid && sent < 30 && $urandom_range(0, 3) != 0) begin
        f = rand_frame();
        s_data = f;
        s_valid = 1'b1;
      end
      acc = s_valid && s_ready;
      if (acc) begin
        lat = $urandom_range(1, 9);
        lat_q.push_back(lat);
        exp_q.push_back(lat >= 9 ? exp_tmo() : exp_ok(res_t'(f[OUTPUT_SIZE-1:0])));
        sent++;
      end
      step();
      if (acc) s_valid = 1'b0;
    end
    check("t6_all_sent", sent, 30);
    check("t6_drained", exp_q.size(), 0);
    check("t6_frame_cnt", frame_cnt, 16'(fc0 + 30));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
